// File: rtl/mfp_ahb_sram_controller.sv
// AHB-Lite slave bridging 32-bit bus words onto a 256K x 16 asynchronous SRAM.
// Each word becomes two halfword accesses; HREADYOUT stretches the data phase.
module mfp_ahb_sram_controller #(
    parameter int ACCESS_CYCLES = 1,
    parameter int SRAM_AW       = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               HSEL,
    input  logic [31:0]        HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [31:0]        HWDATA,
    input  logic               HREADY,
    output logic               HREADYOUT,
    output logic [31:0]        HRDATA,
    output logic               HRESP,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [15:0]        sram_dq_in,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, WR_LO, WR_LO_END, WR_HI, WR_HI_END, DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t             state_q, state_d, startState;
    logic [3:0]         cnt_q, cnt_d;
    logic [SRAM_AW-2:0] addr_q;
    logic [3:0]         lanes_q, laneMask;
    logic [31:0]        wdata_q, hrdata_q, writeData;
    logic               firstData_q;
    logic               acceptNow, phaseEnd, isHi;
    logic [1:0]         laneHalf;
    logic               unusedBits;

    assign unusedBits = ^{HADDR[31:SRAM_AW+1], HTRANS[0]};

    always_comb begin
        laneMask = 4'b1111;
        case (HSIZE)
            3'd0:    laneMask = 4'b0001 << HADDR[1:0];
            3'd1:    laneMask = HADDR[1] ? 4'b1100 : 4'b0011;
            default: laneMask = 4'b1111;
        endcase
    end

    assign acceptNow  = HSEL & HREADY & HTRANS[1] & ((state_q == IDLE) | (state_q == DONE));
    assign startState = !HWRITE ? RD_LO : ((laneMask[1:0] != 2'b00) ? WR_LO : WR_HI);
    assign phaseEnd   = (cnt_q == LAST_CNT);

    // The first data-phase cycle drives HWDATA straight through; later cycles use the captured copy.
    assign isHi      = (state_q == RD_HI) | (state_q == WR_HI) | (state_q == WR_HI_END);
    assign writeData = firstData_q ? HWDATA : wdata_q;
    assign laneHalf  = isHi ? lanes_q[3:2] : lanes_q[1:0];
    assign sram_addr = {addr_q, isHi};
    assign HRDATA    = hrdata_q;
    assign HRESP     = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            lanes_q     <= 4'd0;
            wdata_q     <= 32'd0;
            hrdata_q    <= 32'd0;
            firstData_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            firstData_q <= acceptNow & HWRITE;
            if (acceptNow) begin
                addr_q  <= HADDR[SRAM_AW:2];
                lanes_q <= laneMask;
            end
            if (firstData_q) wdata_q <= HWDATA;
            if (state_q == RD_LO && phaseEnd) hrdata_q[15:0]  <= sram_dq_in;
            if (state_q == RD_HI && phaseEnd) hrdata_q[31:16] <= sram_dq_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        HREADYOUT   = 1'b0;
        sram_ce_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_we_n   = 1'b1;
        sram_ub_n   = 1'b1;
        sram_lb_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = 16'd0;
        case (state_q)
            IDLE, DONE: begin
                HREADYOUT = 1'b1;
                cnt_d     = 4'd0;
                state_d   = acceptNow ? startState : IDLE;
            end
            RD_LO, RD_HI: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
                if (phaseEnd) begin
                    cnt_d   = 4'd0;
                    state_d = (state_q == RD_LO) ? RD_HI : DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_LO, WR_HI: begin
                sram_ce_n   = 1'b0;
                sram_we_n   = 1'b0;
                sram_dq_oe  = 1'b1;
                sram_dq_out = isHi ? writeData[31:16] : writeData[15:0];
                sram_ub_n   = ~laneHalf[1];
                sram_lb_n   = ~laneHalf[0];
                if (phaseEnd) begin
                    cnt_d   = 4'd0;
                    state_d = (state_q == WR_LO) ? WR_LO_END : WR_HI_END;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_LO_END, WR_HI_END: begin
                // Hold address, data and lanes one cycle after we_n rises.
                sram_ce_n   = 1'b0;
                sram_dq_oe  = 1'b1;
                sram_dq_out = isHi ? writeData[31:16] : writeData[15:0];
                sram_ub_n   = ~laneHalf[1];
                sram_lb_n   = ~laneHalf[0];
                cnt_d       = 4'd0;
                if (state_q == WR_LO_END && lanes_q[3:2] != 2'b00) state_d = WR_HI;
                else                                                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

endmodule
